// File: rtl/btn_event_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : btn_event_ctrl
// Brief    : Button synchroniser/debouncer with a press-event FIFO.
// Revision : 1.0
// ============================================================================
module btn_event_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    btnRaw,
  input  logic                          pop,
  output logic [3:0]                    btnLevel,
  output logic [3:0]                    evtData,
  output logic                          evtValid,
  output logic [$clog2(FIFO_DEPTH):0]   evtCount,
  output logic                          overflow,
  input  logic                          clrOvf
);

  localparam int                 c_aw      = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_aw:0]      c_depth   = (c_aw + 1)'(FIFO_DEPTH);

  logic [3:0]       w_n;
  logic [3:0]       r_s1;
  logic [3:0]       r_s2;
  logic [3:0]       r_st;
  logic [3:0]       w_press;
  logic [CNT_W-1:0] r_cnt [4];

  logic [3:0]       r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]  r_wp;
  logic [c_aw-1:0]  r_rp;
  logic [c_aw:0]    r_count;
  logic             r_ovf;

  logic             w_push;
  logic             w_empty;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_drop;

  assign w_n = ACTIVE_LOW ? ~btnRaw : btnRaw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_n;
      r_s2 <= r_s1;
    end
  end

  // Per-bit debounce: the count restarts whenever the input agrees with st again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_s2[i] == r_st[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] != c_cnt_max) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else begin
          r_st[i]  <= r_s2[i];
          r_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_press = '0;
    for (int i = 0; i < 4; i++) begin
      w_press[i] = r_s2[i] && !r_st[i] && (r_cnt[i] == c_cnt_max);
    end
  end

  assign w_push    = |w_press;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_depth);
  assign w_do_pop  = pop && !w_empty;
  // A pop on the same edge frees a slot, so a full queue still accepts the push.
  assign w_do_push = w_push && (!w_full || w_do_pop);
  assign w_drop    = w_push && w_full && !w_do_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wp] <= w_press;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_do_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clrOvf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign btnLevel = r_st;
  assign evtValid = !w_empty;
  assign evtData  = w_empty ? 4'b0000 : r_mem[r_rp];
  assign evtCount = r_count;
  assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
- Input front-end for the push buttons that drive the processor's 4-bit button input.
- Synchronises and debounces the raw buttons, and publishes debounced levels.
- Queues press events in a small FIFO. The core consumes one event at a time via a pop strobe.
- Sits between the board pins and the processor top, in the same single clock domain.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronised input must differ from the stable level before the stable level changes (>=2)
CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1
FIFO_DEPTH, 4, event queue entries (power of two, >=2)
ACTIVE_LOW, 1, 1 = raw pins read 0 when pressed; inverted before the synchroniser

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
btnRaw  input  4  raw button pins
pop  input  1  consumer removes the head event this cycle
btnLevel  output  4  debounced levels, 1 = pressed
evtData  output  4  head event mask, bit i = button i pressed; 0 when empty
evtValid  output  1  FIFO non-empty
evtCount  output  $clog2(FIFO_DEPTH)+1  number of queued events
overflow  output  1  sticky, an event was dropped
clrOvf  input  1  clears overflow

Behaviour:
- Reset (async, active-high): sync flops, stable levels, counters, FIFO pointers and count all go to 0.
  - btnLevel=0, evtData=0, evtValid=0, evtCount=0, overflow=0.
  - Reset asserted mid-debounce or with queued events discards everything immediately.
- Polarity: n = ACTIVE_LOW ? ~btnRaw : btnRaw. Two-flop synchroniser per bit: s1<=n, s2<=s1.
- Debounce, independent per bit i, with counter cnt[i] and stable level st[i]:
  - s2==st: cnt<=0.
  - s2!=st and cnt!=DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - s2!=st and cnt==DEBOUNCE_CYCLES-1: st<=s2, cnt<=0.
  - Any return to s2==st before the threshold restarts the count, so glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
- Latency: a raw change first sampled at edge k appears on btnLevel after edge k+1+DEBOUNCE_CYCLES.
- btnLevel = st (registered).
- Press detect:
  - pressMask[i] = 1 in the cycle the rule above sets st[i] 0->1.
  - Releases generate no events.
  - Presses of several buttons completing on the same edge form ONE event holding the OR mask.
- Push = (pressMask != 0). The push writes at the same edge st updates, so evtValid/evtData reflect the event after that edge.
- FIFO rules, with full = (evtCount==FIFO_DEPTH):
  - First-word-fall-through: evtData = head entry when evtValid, else 0.
  - pop while empty: ignored, with no pointer or count change.
  - push and pop in the same cycle while non-empty: both happen, count unchanged. This includes when full, in which case no drop occurs.
  - push while full and no pop: event dropped, overflow<=1.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow:
  - Sticky until clrOvf=1 clears it on the next edge.
  - If clrOvf and a new drop occur in the same cycle, the drop wins and overflow stays 1.
- A button held through reset release is seen as a new press: one event after DEBOUNCE_CYCLES+2 edges.
- All outputs are registered or derived from registers only; there is no combinational path from btnRaw, pop or clrOvf to any output.

Test Plan:
- DEBOUNCE_CYCLES=4, ACTIVE_LOW=1; btnRaw[0] drives 1->0 before edge 10 and is held -> btnLevel=4'b0001, evtValid=1 and evtData=4'b0001 after edge 15; pop at the next edge -> evtValid=0, evtData=0, evtCount=0.
- Glitch: btnRaw[2] low for 3 cycles then high -> btnLevel stays 0, no event, cnt[2] returns to 0.
- Simultaneous: buttons 1 and 3 pressed on the same cycle -> single event 4'b1010, evtCount=1; the release of both produces no event.
- Overflow: 5 separate presses with no pop (FIFO_DEPTH=4) -> evtCount=4, overflow=1, head=first event. Next: push+pop on the same cycle while full -> count stays 4 and overflow is unchanged. clrOvf -> overflow=0.
- Wrap: 6 press/pop pairs interleaved -> evtData order matches press order across pointer wrap; pop on empty leaves evtCount=0.
- Reset mid-operation: reset asserted with 2 queued events and a debounce count in progress -> all outputs 0 immediately (async). Button still held at release -> one event after edge DEBOUNCE_CYCLES+2.
